// File: rtl/wb_stim_slave_pkg.sv
// Shared types and constants for the Wishbone stimulus slave and its FIFOs.
package wb_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INST          = 32'hE1A0_0000;
  localparam logic [31:0] ERR_DATA          = 32'hDEAD_BEEF;
  localparam logic [31:0] DEFAULT_DATA_BASE = 32'h0001_0000;
  localparam int          WCAP_W            = 68;

  function automatic logic [WCAP_W-1:0] wcap_pack(input logic [31:0] adr,
                                                  input logic [31:0] dat,
                                                  input logic [3:0]  sel);
    return {adr, dat, sel};
  endfunction

endpackage

// File: rtl/wb_stim_slave_if.sv
// Bus, push-side and store-capture signals of the stimulus slave, grouped for port use.
interface wb_stim_if;
  logic [31:0] i_wb_adr;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic [31:0] i_wb_dat;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack;
  logic        o_wb_err;

  logic        i_inst_valid;
  logic [31:0] i_inst;
  logic        o_inst_ready;
  logic        i_data_valid;
  logic [31:0] i_data;
  logic        o_data_ready;

  logic        o_wr_valid;
  logic [31:0] o_wr_adr;
  logic [31:0] o_wr_dat;
  logic [3:0]  o_wr_sel;
  logic        i_wr_ready;

  logic [15:0] o_fetch_cnt;
  logic [15:0] o_load_cnt;
  logic [15:0] o_store_cnt;

  modport slave (
    input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    output o_wb_dat, o_wb_ack, o_wb_err,
    input  i_inst_valid, i_inst, output o_inst_ready,
    input  i_data_valid, i_data, output o_data_ready,
    output o_wr_valid, o_wr_adr, o_wr_dat, o_wr_sel, input i_wr_ready,
    output o_fetch_cnt, o_load_cnt, o_store_cnt
  );

  modport master (
    output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
    input  o_wb_dat, o_wb_ack, o_wb_err,
    output i_inst_valid, i_inst, input o_inst_ready,
    output i_data_valid, i_data, input o_data_ready,
    input  o_wr_valid, o_wr_adr, o_wr_dat, o_wr_sel, output i_wr_ready,
    input  o_fetch_cnt, o_load_cnt, o_store_cnt
  );
endinterface

// File: rtl/wb_stim_slave_fifo.sv
// Synchronous FIFO; full/empty come from an occupancy count so pointer wrap is unambiguous.
module wb_stim_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (do_push && !i_rst) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/wb_stim_slave.sv
// Wishbone slave that serves fetches/loads from pushed FIFOs and captures stores.
//   state | meaning
//   IDLE  | waiting for cyc&&stb; latches the request (writes stall while WCAP is full)
//   WAIT  | counting ACK_LAT wait states; cyc drop abandons the transfer
//   ACK   | one-cycle ack/err with pop, push and counter update
module wb_stim_slave
  import wb_stim_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter int          ACK_LAT   = 0,
  parameter logic [31:0] DATA_BASE = DEFAULT_DATA_BASE
) (
  input  logic        clk,
  input  logic        i_rst,
  wb_stim_if.slave    bus
);
  localparam logic [1:0] LAT_LOAD = (ACK_LAT > 0) ? 2'(ACK_LAT - 1) : 2'd0;
  localparam bit         HAS_WAIT = (ACK_LAT > 0);

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] load_cnt_q, load_cnt_d;
  logic [15:0] store_cnt_q, store_cnt_d;

  logic              inst_full, inst_empty, inst_pop;
  logic [31:0]       inst_head;
  logic              data_full, data_empty, data_pop;
  logic [31:0]       data_head;
  logic              wcap_full, wcap_empty, wcap_push;
  logic [WCAP_W-1:0] wcap_head;

  logic        wb_ack, wb_err;
  logic [31:0] wb_dat;

  wb_stim_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_inst (
    .clk(clk), .i_rst(i_rst), .i_push(bus.i_inst_valid), .i_data(bus.i_inst),
    .i_pop(inst_pop), .o_data(inst_head), .o_full(inst_full), .o_empty(inst_empty)
  );

  wb_stim_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_data (
    .clk(clk), .i_rst(i_rst), .i_push(bus.i_data_valid), .i_data(bus.i_data),
    .i_pop(data_pop), .o_data(data_head), .o_full(data_full), .o_empty(data_empty)
  );

  wb_stim_fifo #(.WIDTH(WCAP_W), .DEPTH(DEPTH)) u_wcap (
    .clk(clk), .i_rst(i_rst), .i_push(wcap_push), .i_data(wcap_pack(adr_q, dat_q, sel_q)),
    .i_pop(bus.i_wr_ready), .o_data(wcap_head), .o_full(wcap_full), .o_empty(wcap_empty)
  );

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    we_d        = we_q;
    lat_cnt_d   = lat_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    load_cnt_d  = load_cnt_q;
    store_cnt_d = store_cnt_q;
    inst_pop    = 1'b0;
    data_pop    = 1'b0;
    wcap_push   = 1'b0;
    wb_ack      = 1'b0;
    wb_err      = 1'b0;
    wb_dat      = '0;
    case (state_q)
      IDLE: begin
        if (bus.i_wb_cyc && bus.i_wb_stb && !(bus.i_wb_we && wcap_full)) begin
          adr_d = bus.i_wb_adr;
          dat_d = bus.i_wb_dat;
          sel_d = bus.i_wb_sel;
          we_d  = bus.i_wb_we;
          if (HAS_WAIT) begin
            state_d   = WAIT;
            lat_cnt_d = LAT_LOAD;
          end else begin
            state_d = ACK;
          end
        end
      end
      WAIT: begin
        if (!bus.i_wb_cyc)         state_d = IDLE;
        else if (lat_cnt_q == 2'd0) state_d = ACK;
        else                        lat_cnt_d = lat_cnt_q - 2'd1;
      end
      ACK: begin
        state_d = IDLE;
        if (we_q) begin
          wb_ack      = 1'b1;
          wcap_push   = 1'b1;
          store_cnt_d = store_cnt_q + 16'd1;
        end else if (adr_q < DATA_BASE) begin
          // An empty INST still acks, feeding the core a NOP instead of stalling it.
          wb_ack      = 1'b1;
          fetch_cnt_d = fetch_cnt_q + 16'd1;
          if (inst_empty) begin
            wb_dat = NOP_INST;
          end else begin
            wb_dat   = inst_head;
            inst_pop = 1'b1;
          end
        end else if (data_empty) begin
          wb_err = 1'b1;
          wb_dat = ERR_DATA;
        end else begin
          wb_ack     = 1'b1;
          wb_dat     = data_head;
          data_pop   = 1'b1;
          load_cnt_d = load_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      lat_cnt_q   <= '0;
      fetch_cnt_q <= '0;
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      lat_cnt_q   <= lat_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      load_cnt_q  <= load_cnt_d;
      store_cnt_q <= store_cnt_d;
    end
  end

  // Reset masks the response of a transfer caught in ACK, so it is abandoned silently.
  assign bus.o_wb_ack     = wb_ack && !i_rst;
  assign bus.o_wb_err     = wb_err && !i_rst;
  assign bus.o_wb_dat     = i_rst ? '0 : wb_dat;
  assign bus.o_inst_ready = !inst_full;
  assign bus.o_data_ready = !data_full;
  assign bus.o_wr_valid   = !wcap_empty && !i_rst;
  assign bus.o_wr_adr     = wcap_head[67:36];
  assign bus.o_wr_dat     = wcap_head[35:4];
  assign bus.o_wr_sel     = wcap_head[3:0];
  assign bus.o_fetch_cnt  = fetch_cnt_q;
  assign bus.o_load_cnt   = load_cnt_q;
  assign bus.o_store_cnt  = store_cnt_q;

endmodule

// File: tb/tb_wb_stim_slave.sv
// Bench for wb_stim_slave: two instances (ACK_LAT 0 and 2) against a queue-based model.
module tb_wb_stim_slave;
  import wb_stim_pkg::*;

  localparam int TB_DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        which = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic        inst_valid = 1'b0, data_valid = 1'b0, wr_ready = 1'b0;
  logic [31:0] inst = '0, data = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] inst_m[$];
  logic [31:0] data_m[$];
  logic [67:0] wcap_m[$];
  int f_m, l_m, s_m;

  wb_stim_if if0 ();
  wb_stim_if if2 ();

  wb_stim_slave #(.DEPTH(TB_DEPTH), .ACK_LAT(0)) dut0 (.clk(clk), .i_rst(rst), .bus(if0.slave));
  wb_stim_slave #(.DEPTH(TB_DEPTH), .ACK_LAT(2)) dut2 (.clk(clk), .i_rst(rst), .bus(if2.slave));

  assign if0.i_wb_adr = adr;  assign if2.i_wb_adr = adr;
  assign if0.i_wb_sel = sel;  assign if2.i_wb_sel = sel;
  assign if0.i_wb_we  = we;   assign if2.i_wb_we  = we;
  assign if0.i_wb_dat = wdat; assign if2.i_wb_dat = wdat;
  assign if0.i_inst   = inst; assign if2.i_inst   = inst;
  assign if0.i_data   = data; assign if2.i_data   = data;
  assign if0.i_wb_cyc     = cyc && !which;        assign if2.i_wb_cyc     = cyc && which;
  assign if0.i_wb_stb     = stb && !which;        assign if2.i_wb_stb     = stb && which;
  assign if0.i_inst_valid = inst_valid && !which; assign if2.i_inst_valid = inst_valid && which;
  assign if0.i_data_valid = data_valid && !which; assign if2.i_data_valid = data_valid && which;
  assign if0.i_wr_ready   = wr_ready && !which;   assign if2.i_wr_ready   = wr_ready && which;

  logic        obs_ack, obs_err, obs_inst_ready, obs_data_ready, obs_wr_valid;
  logic [31:0] obs_dat, obs_wr_adr, obs_wr_dat;
  logic [3:0]  obs_wr_sel;
  logic [15:0] obs_fcnt, obs_lcnt, obs_scnt;

  assign obs_ack        = which ? if2.o_wb_ack     : if0.o_wb_ack;
  assign obs_err        = which ? if2.o_wb_err     : if0.o_wb_err;
  assign obs_dat        = which ? if2.o_wb_dat     : if0.o_wb_dat;
  assign obs_inst_ready = which ? if2.o_inst_ready : if0.o_inst_ready;
  assign obs_data_ready = which ? if2.o_data_ready : if0.o_data_ready;
  assign obs_wr_valid   = which ? if2.o_wr_valid   : if0.o_wr_valid;
  assign obs_wr_adr     = which ? if2.o_wr_adr     : if0.o_wr_adr;
  assign obs_wr_dat     = which ? if2.o_wr_dat     : if0.o_wr_dat;
  assign obs_wr_sel     = which ? if2.o_wr_sel     : if0.o_wr_sel;
  assign obs_fcnt       = which ? if2.o_fetch_cnt  : if0.o_fetch_cnt;
  assign obs_lcnt       = which ? if2.o_load_cnt   : if0.o_load_cnt;
  assign obs_scnt       = which ? if2.o_store_cnt  : if0.o_store_cnt;

  function automatic int lat_of();
    return which ? 2 : 0;
  endfunction

  function automatic void model_clear();
    inst_m.delete(); data_m.delete(); wcap_m.delete();
    f_m = 0; l_m = 0; s_m = 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    inst_valid = 1'b0; data_valid = 1'b0; wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic push_inst(input logic [31:0] v);
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = (inst_m.size() < TB_DEPTH);
    checks++;
    if (obs_inst_ready !== exp_rdy) begin
      errors++;
      $display("FAIL inst_ready got=%b exp=%b", obs_inst_ready, exp_rdy);
    end
    inst_valid = 1'b1; inst = v;
    if (exp_rdy) inst_m.push_back(v);
    @(negedge clk);
    inst_valid = 1'b0;
  endtask

  task automatic push_data(input logic [31:0] v);
    logic exp_rdy;
    @(negedge clk);
    exp_rdy = (data_m.size() < TB_DEPTH);
    checks++;
    if (obs_data_ready !== exp_rdy) begin
      errors++;
      $display("FAIL data_ready got=%b exp=%b", obs_data_ready, exp_rdy);
    end
    data_valid = 1'b1; data = v;
    if (exp_rdy) data_m.push_back(v);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wb_start(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    adr = a; we = w; wdat = d; sel = s; cyc = 1'b1; stb = 1'b1;
  endtask

  // Returns at the negedge where ack/err is seen (and releases the bus), or after bound cycles.
  task automatic wb_wait(input int bound, output bit done, output logic ack_o, output logic err_o,
                         output logic [31:0] dat_o, output int lat);
    done = 1'b0; ack_o = 1'b0; err_o = 1'b0; dat_o = '0; lat = 0;
    while (!done && lat < bound) begin
      @(negedge clk);
      lat++;
      if (obs_ack || obs_err) begin
        done = 1'b1; ack_o = obs_ack; err_o = obs_err; dat_o = obs_dat;
        cyc = 1'b0; stb = 1'b0;
      end else begin
        checks++;
        if (obs_dat !== 32'h0) begin
          errors++;
          $display("FAIL idle_dat got=%h exp=00000000", obs_dat);
        end
      end
    end
  endtask

  task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                         output logic ack_o, output logic err_o, output logic [31:0] dat_o, output int lat);
    bit done;
    wb_start(a, w, d, s);
    wb_wait(12, done, ack_o, err_o, dat_o, lat);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout adr=%h got no ack/err in 12 cycles, exp ack or err", a);
      cyc = 1'b0; stb = 1'b0;
    end
  endtask

  task automatic drain_wcap();
    logic [67:0] exp;
    while (wcap_m.size() > 0) begin
      exp = wcap_m.pop_front();
      checks++;
      if (obs_wr_valid !== 1'b1 || {obs_wr_adr, obs_wr_dat, obs_wr_sel} !== exp) begin
        errors++;
        $display("FAIL wcap_head got=%b/%h exp=1/%h", obs_wr_valid,
                 {obs_wr_adr, obs_wr_dat, obs_wr_sel}, exp);
      end
      wr_ready = 1'b1;
      @(negedge clk);
      wr_ready = 1'b0;
    end
    checks++;
    if (obs_wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL wcap_empty wr_valid got=%b exp=0", obs_wr_valid);
    end
  endtask

  task automatic test_reset();
    for (int w = 0; w < 2; w++) begin
      which = w[0];
      do_reset();
      checks++;
      if ({obs_ack, obs_err, obs_wr_valid, obs_inst_ready, obs_data_ready} !== 5'b00011) begin
        errors++;
        $display("FAIL reset_flags dut=%0d got=%b exp=00011", w,
                 {obs_ack, obs_err, obs_wr_valid, obs_inst_ready, obs_data_ready});
      end
      checks++;
      if ({obs_fcnt, obs_lcnt, obs_scnt, obs_dat} !== 80'h0) begin
        errors++;
        $display("FAIL reset_cnt_dat dut=%0d got=%h/%h/%h/%h exp=0", w, obs_fcnt, obs_lcnt, obs_scnt, obs_dat);
      end
    end
  endtask

  task automatic test_fetch();
    logic ack, err; logic [31:0] rd; int lat;
    which = 1'b0; do_reset();
    push_inst(32'hE3A0_1005);
    wb_xfer(32'h0, 1'b0, '0, 4'hF, ack, err, rd, lat);
    checks++;
    if ({ack, err, rd} !== {2'b10, 32'hE3A0_1005} || lat != 1) begin
      errors++;
      $display("FAIL fetch got=%b%b/%h lat=%0d exp=10/e3a01005 lat=1", ack, err, rd, lat);
    end
    @(negedge clk);
    checks++;
    if (obs_fcnt !== 16'd1) begin
      errors++;
      $display("FAIL fetch_cnt got=%0d exp=1", obs_fcnt);
    end
  endtask

  task automatic test_nop();
    logic ack, err; logic [31:0] rd; int lat;
    which = 1'b0; do_reset();
    for (int k = 0; k < 2; k++) begin
      wb_xfer(32'h4, 1'b0, '0, 4'hF, ack, err, rd, lat);
      checks++;
      if ({ack, err, rd} !== {2'b10, NOP_INST}) begin
        errors++;
        $display("FAIL nop_fetch%0d got=%b%b/%h exp=10/%h", k, ack, err, rd, NOP_INST);
      end
    end
    @(negedge clk);
    checks++;
    if (obs_fcnt !== 16'd2) begin
      errors++;
      $display("FAIL nop_fetch_cnt got=%0d exp=2", obs_fcnt);
    end
  endtask

  task automatic test_load_lat2();
    logic ack, err; logic [31:0] rd; int lat;
    which = 1'b1; do_reset();
    push_data(32'h1234_5678);
    wb_xfer(32'h0001_0000, 1'b0, '0, 4'hF, ack, err, rd, lat);
    checks++;
    if ({ack, err, rd} !== {2'b10, 32'h1234_5678} || lat != 3) begin
      errors++;
      $display("FAIL load got=%b%b/%h lat=%0d exp=10/12345678 lat=3", ack, err, rd, lat);
    end
    wb_xfer(32'h0001_0000, 1'b0, '0, 4'hF, ack, err, rd, lat);
    checks++;
    if ({ack, err, rd} !== {2'b01, ERR_DATA}) begin
      errors++;
      $display("FAIL load_empty got=%b%b/%h exp=01/deadbeef", ack, err, rd);
    end
    @(negedge clk);
    checks++;
    if (obs_lcnt !== 16'd1) begin
      errors++;
      $display("FAIL load_cnt got=%0d exp=1", obs_lcnt);
    end
  endtask

  task automatic test_wcap_stall();
    logic ack, err; logic [31:0] rd; int lat; bit done;
    which = 1'b0; do_reset();
    for (int i = 0; i < TB_DEPTH; i++) begin
      wb_xfer(32'h100 + 32'(4*i), 1'b1, 32'hAA + 32'(i), 4'hF, ack, err, rd, lat);
      wcap_m.push_back({32'h100 + 32'(4*i), 32'hAA + 32'(i), 4'hF});
      checks++;
      if ({ack, err} !== 2'b10) begin
        errors++;
        $display("FAIL wr_ack%0d got=%b%b exp=10", i, ack, err);
      end
    end
    wb_start(32'h200, 1'b1, 32'hBB, 4'h3);
    wb_wait(6, done, ack, err, rd, lat);
    checks++;
    if (done) begin
      errors++;
      $display("FAIL wr_stall got=ack/err exp=no response while WCAP full");
    end
    checks++;
    if (obs_wr_valid !== 1'b1 || {obs_wr_adr, obs_wr_dat, obs_wr_sel} !== {32'h100, 32'hAA, 4'hF}) begin
      errors++;
      $display("FAIL wcap_first got=%b/%h/%h/%h exp=1/100/aa/f", obs_wr_valid, obs_wr_adr, obs_wr_dat, obs_wr_sel);
    end
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    void'(wcap_m.pop_front());
    wb_wait(6, done, ack, err, rd, lat);
    checks++;
    if (!done || {ack, err} !== 2'b10) begin
      errors++;
      $display("FAIL wr_unstall got=%b/%b%b exp=1/10", done, ack, err);
      cyc = 1'b0; stb = 1'b0;
    end
    wcap_m.push_back({32'h200, 32'hBB, 4'h3});
    @(negedge clk);
    checks++;
    if (obs_scnt !== 16'd9) begin
      errors++;
      $display("FAIL store_cnt got=%0d exp=9", obs_scnt);
    end
    drain_wcap();
  endtask

  task automatic test_reset_in_wait();
    logic ack, err; logic [31:0] rd; int lat;
    which = 1'b1; do_reset();
    for (int i = 0; i < 3; i++) push_inst(32'hC0DE_0000 + 32'(i));
    wb_xfer(32'h0, 1'b0, '0, 4'hF, ack, err, rd, lat);
    void'(inst_m.pop_front());
    wb_start(32'h0, 1'b0, '0, 4'hF);
    @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({obs_ack, obs_err} !== 2'b00) begin
        errors++;
        $display("FAIL rst_wait_resp got=%b%b exp=00", obs_ack, obs_err);
      end
    end
    rst = 1'b0;
    model_clear();
    checks++;
    if ({obs_fcnt, obs_lcnt, obs_scnt} !== 48'h0 || obs_wr_valid !== 1'b0 || obs_inst_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_state got=%h/%h/%h wrv=%b rdy=%b exp=0/0/0 wrv=0 rdy=1",
               obs_fcnt, obs_lcnt, obs_scnt, obs_wr_valid, obs_inst_ready);
    end
    wb_xfer(32'h0, 1'b0, '0, 4'hF, ack, err, rd, lat);
    checks++;
    if ({ack, err, rd} !== {2'b10, NOP_INST}) begin
      errors++;
      $display("FAIL rst_wait_nop got=%b%b/%h exp=10/%h", ack, err, rd, NOP_INST);
    end
  endtask

  task automatic test_cyc_drop();
    logic ack, err; logic [31:0] rd; int lat;
    which = 1'b1; do_reset();
    push_inst(32'hAAAA_0001);
    push_inst(32'hBBBB_0002);
    wb_start(32'h8, 1'b0, '0, 4'hF);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({obs_ack, obs_err} !== 2'b00) begin
        errors++;
        $display("FAIL drop_resp got=%b%b exp=00", obs_ack, obs_err);
      end
    end
    checks++;
    if (obs_fcnt !== 16'd0) begin
      errors++;
      $display("FAIL drop_cnt got=%0d exp=0", obs_fcnt);
    end
    wb_xfer(32'h8, 1'b0, '0, 4'hF, ack, err, rd, lat);
    checks++;
    if ({ack, err, rd} !== {2'b10, 32'hAAAA_0001} || lat != 3) begin
      errors++;
      $display("FAIL drop_refetch got=%b%b/%h lat=%0d exp=10/aaaa0001 lat=3", ack, err, rd, lat);
    end
  endtask

  task automatic test_random(input logic w);
    logic ack, err; logic [31:0] rd, a, d, exp_d; logic [3:0] s; int lat; int op;
    logic [1:0] exp_ae;
    which = w; do_reset();
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: push_inst($urandom);
        1: push_data($urandom);
        2: begin
          a = 32'($urandom_range(0, 32'h3FFF)) << 2;
          wb_xfer(a, 1'b0, '0, 4'hF, ack, err, rd, lat);
          exp_d = (inst_m.size() > 0) ? inst_m.pop_front() : NOP_INST;
          f_m++;
          checks++;
          if ({ack, err, rd} !== {2'b10, exp_d} || lat != 1 + lat_of()) begin
            errors++;
            $display("FAIL rand_fetch got=%b%b/%h lat=%0d exp=10/%h lat=%0d", ack, err, rd, lat, exp_d, 1 + lat_of());
          end
        end
        3: begin
          a = DEFAULT_DATA_BASE + (32'($urandom_range(0, 255)) << 2);
          wb_xfer(a, 1'b0, '0, 4'hF, ack, err, rd, lat);
          if (data_m.size() > 0) begin
            exp_ae = 2'b10; exp_d = data_m.pop_front(); l_m++;
          end else begin
            exp_ae = 2'b01; exp_d = ERR_DATA;
          end
          checks++;
          if ({ack, err, rd} !== {exp_ae, exp_d} || lat != 1 + lat_of()) begin
            errors++;
            $display("FAIL rand_load got=%b%b/%h lat=%0d exp=%b/%h lat=%0d", ack, err, rd, lat, exp_ae, exp_d, 1 + lat_of());
          end
        end
        default: begin
          if (wcap_m.size() < TB_DEPTH) begin
            a = $urandom & 32'hFFFF_FFFC; d = $urandom; s = 4'($urandom_range(1, 15));
            wb_xfer(a, 1'b1, d, s, ack, err, rd, lat);
            wcap_m.push_back({a, d, s});
            s_m++;
            checks++;
            if ({ack, err} !== 2'b10 || lat != 1 + lat_of()) begin
              errors++;
              $display("FAIL rand_write got=%b%b lat=%0d exp=10 lat=%0d", ack, err, lat, 1 + lat_of());
            end
          end
        end
      endcase
    end
    @(negedge clk);
    checks++;
    if ({obs_fcnt, obs_lcnt, obs_scnt} !== {16'(f_m), 16'(l_m), 16'(s_m)}) begin
      errors++;
      $display("FAIL rand_counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", obs_fcnt, obs_lcnt, obs_scnt, f_m, l_m, s_m);
    end
    drain_wcap();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_fetch();
    test_nop();
    test_load_lat2();
    test_wcap_stall();
    test_reset_in_wait();
    test_cyc_drop();
    test_random(1'b0);
    test_random(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
